// File: rtl/page_pattern_scanner.sv
// Page-pattern scanner: one block of PPB pages per SCAN cycle vs NPAT patterns; optional `PAT_MASK_EN adds per-bit masks.
// start->busy 1 cycle, zero-hit scan ends after NOB+1 busy cycles; out_idx/out_valid hold while out_ready=0.
module page_pattern_scanner #(
  parameter int P_W  = 12,
  parameter int PPB  = 8,
  parameter int NOB  = 3,
  parameter int NPAT = 4,
  localparam int ARR_W = P_W * PPB * NOB,
  localparam int IDX_W = $clog2(PPB * NOB),
  localparam int CNT_W = $clog2(PPB * NOB + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ARR_W-1:0]      arr,
  input  logic [NPAT*P_W-1:0]   pat,
  input  logic [NPAT-1:0]       pat_en,
`ifdef PAT_MASK_EN
  input  logic [NPAT*P_W-1:0]   pat_mask,
`endif
  output logic                  busy,
  output logic                  out_valid,
  output logic [IDX_W-1:0]      out_idx,
  input  logic                  out_ready,
  output logic                  done,
  output logic [CNT_W-1:0]      match_cnt
);

  localparam int BLK_W = (NOB > 1) ? $clog2(NOB) : 1;
  localparam int PIDX_W = (PPB > 1) ? $clog2(PPB) : 1;
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NOB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]                        state;
  logic [BLK_W-1:0]                  blk;
  logic [PPB-1:0]                    pend;
  logic [NOB-1:0][PPB-1:0][P_W-1:0]  arr_q;
  logic [NPAT-1:0][P_W-1:0]          pat_q;
  logic [NPAT-1:0]                   pat_en_q;
`ifdef PAT_MASK_EN
  logic [NPAT-1:0][P_W-1:0]          mask_q;
`endif

  logic [PPB-1:0][P_W-1:0] page_v;
  logic [PPB-1:0]          hit;
  logic [PPB-1:0]          pend_rest;
  logic [IDX_W-1:0]        blk_base;

  function automatic logic [PIDX_W-1:0] lowest(input logic [PPB-1:0] v);
    logic [PIDX_W-1:0] r;
    r = '0;
    for (int i = PPB - 1; i >= 0; i--) begin
      if (v[i]) r = PIDX_W'(i);
    end
    return r;
  endfunction

  // Block mux over constant selects so blk never indexes past NOB-1.
  always_comb begin
    page_v = '0;
    for (int b = 0; b < NOB; b++) begin
      if (blk == BLK_W'(b)) page_v = arr_q[b];
    end
  end

  // A page hits when any enabled pattern matches; several hits on one page still set one bit.
  always_comb begin
    hit = '0;
    for (int i = 0; i < PPB; i++) begin
      for (int j = 0; j < NPAT; j++) begin
`ifdef PAT_MASK_EN
        if (pat_en_q[j] && (((page_v[i] ^ pat_q[j]) & mask_q[j]) == '0)) hit[i] = 1'b1;
`else
        if (pat_en_q[j] && (page_v[i] == pat_q[j])) hit[i] = 1'b1;
`endif
      end
    end
  end

  assign pend_rest = pend & (pend - PPB'(1));
  assign blk_base  = IDX_W'(blk) * IDX_W'(PPB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      blk       <= '0;
      pend      <= '0;
      arr_q     <= '0;
      pat_q     <= '0;
      pat_en_q  <= '0;
`ifdef PAT_MASK_EN
      mask_q    <= '0;
`endif
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      done      <= 1'b0;
      match_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            arr_q     <= arr;
            pat_q     <= pat;
            pat_en_q  <= pat_en;
`ifdef PAT_MASK_EN
            mask_q    <= pat_mask;
`endif
            blk       <= '0;
            match_cnt <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          pend <= hit;
          if (|hit) begin
            out_valid <= 1'b1;
            out_idx   <= blk_base + IDX_W'(lowest(hit));
            state     <= EMIT;
          end else if (blk == LAST_BLK) begin
            state <= DONE;
          end else begin
            blk <= blk + BLK_W'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            match_cnt <= match_cnt + CNT_W'(1);
            pend      <= pend_rest;
            if (|pend_rest) begin
              out_idx <= blk_base + IDX_W'(lowest(pend_rest));
            end else begin
              out_valid <= 1'b0;
              if (blk == LAST_BLK) begin
                state <= DONE;
              end else begin
                blk   <= blk + BLK_W'(1);
                state <= SCAN;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_page_pattern_scanner.sv
// Bench for page_pattern_scanner: table of scan vectors with expected hit sets, index scoreboard, reset/start abuse.
module tb_page_pattern_scanner;
  localparam int P_W = 12, PPB = 8, NOB = 3, NPAT = 4;
  localparam int ARR_W = P_W * PPB * NOB;
  localparam int NPG = PPB * NOB;
  localparam int IDX_W = $clog2(NPG);
  localparam int CNT_W = $clog2(NPG + 1);
`ifdef PAT_MASK_EN
  localparam int NV = 6;
`else
  localparam int NV = 5;
`endif

  typedef struct {
    logic [ARR_W-1:0]    arr;
    logic [NPAT*P_W-1:0] pat;
    logic [NPAT*P_W-1:0] mask;
    logic [NPAT-1:0]     en;
    logic [NPG-1:0]      hits;
    int                  stall_at;
    int                  stall_n;
    int                  abuse_cyc;
    int                  done_lat;
    bit                  rand_rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [ARR_W-1:0] arr;
  logic [NPAT*P_W-1:0] pat;
  logic [NPAT-1:0] pat_en;
`ifdef PAT_MASK_EN
  logic [NPAT*P_W-1:0] pat_mask;
`endif
  logic busy, out_valid, done;
  logic [IDX_W-1:0] out_idx;
  logic [CNT_W-1:0] match_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  vec_t vec [NV];

  always #5 clk = ~clk;

  page_pattern_scanner dut (
    .clk(clk), .rst(rst), .start(start), .arr(arr), .pat(pat), .pat_en(pat_en),
`ifdef PAT_MASK_EN
    .pat_mask(pat_mask),
`endif
    .busy(busy), .out_valid(out_valid), .out_idx(out_idx), .out_ready(out_ready),
    .done(done), .match_cnt(match_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int stalls;
    bit prev_stall;
    bit seen_done;
    int exp_n;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    arr = v.arr; pat = v.pat; pat_en = v.en; start = 1'b1; out_ready = 1'b1;
`ifdef PAT_MASK_EN
    pat_mask = v.mask;
`endif
    exp_q.delete();
    for (int i = 0; i < NPG; i++) if (v.hits[i]) exp_q.push_back(i);
    exp_n = $countones(v.hits);
    cyc = 0; stalls = v.stall_n; prev_stall = 0; seen_done = 0;
    while (!seen_done && cyc < 400) begin
      @(negedge clk);
      start = (cyc == v.abuse_cyc);
      if (cyc == 0) begin
        chk("busy_rise", busy, 1);
        arr = ~v.arr; pat = ~v.pat; pat_en = ~v.en;
`ifdef PAT_MASK_EN
        pat_mask = ~v.mask;
`endif
      end
      if (prev_stall) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_idx", out_idx, v.stall_at);
      end
      out_ready = v.rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_idx == v.stall_at && stalls > 0) begin
        out_ready = 1'b0; stalls--; prev_stall = 1;
      end else begin
        prev_stall = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_idx", out_idx, {32{1'b1}});
        else chk("idx", out_idx, exp_q.pop_front());
      end
      if (done) begin
        seen_done = 1;
        chk("done_busy", busy, 0);
        chk("match_cnt", match_cnt, exp_n);
        chk("idx_left", exp_q.size(), 0);
        if (v.done_lat >= 0) chk("done_lat", cyc, v.done_lat);
      end
      cyc++;
    end
    chk("done_seen", seen_done, 1);
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    chk("done_pulse", done, 0);
    chk("cnt_hold", match_cnt, exp_n);
    chk("vld_idle", out_valid, 0);
  endtask

  initial begin
    for (int k = 0; k < NV; k++) begin
      vec[k] = '{arr: '0, pat: '0, mask: '1, en: '0, hits: '0,
                 stall_at: -1, stall_n: 0, abuse_cyc: -1, done_lat: -1, rand_rdy: 0};
    end
    // sparse hits with backpressure at index 10 and a start while busy
    vec[0].arr[3*P_W +: P_W] = 12'hABC; vec[0].arr[10*P_W +: P_W] = 12'h123;
    vec[0].arr[23*P_W +: P_W] = 12'hABC;
    vec[0].pat[0 +: P_W] = 12'hABC; vec[0].pat[P_W +: P_W] = 12'h123; vec[0].en = 4'b0011;
    vec[0].hits[3] = 1; vec[0].hits[10] = 1; vec[0].hits[23] = 1;
    vec[0].stall_at = 10; vec[0].stall_n = 5; vec[0].abuse_cyc = 2;
    // no hits, start offered in the DONE cycle
    vec[1] = vec[0]; vec[1].en = '0; vec[1].hits = '0; vec[1].stall_n = 0;
    vec[1].abuse_cyc = 3; vec[1].done_lat = 4;
    // full hits, two patterns on every page
    for (int p = 0; p < NPG; p++) vec[2].arr[p*P_W +: P_W] = 12'h5A5;
    vec[2].pat[2*P_W +: P_W] = 12'h5A5; vec[2].pat[3*P_W +: P_W] = 12'h5A5;
    vec[2].en = 4'b1100; vec[2].hits = '1;
    // disabled pattern must not match
    vec[3] = vec[0]; vec[3].en = 4'b0010; vec[3].hits = '0; vec[3].hits[10] = 1;
    vec[3].stall_n = 0; vec[3].abuse_cyc = -1;
    // block edges, random ready
    vec[4].arr[0 +: P_W] = 12'hFFF; vec[4].arr[7*P_W +: P_W] = 12'h001;
    vec[4].arr[8*P_W +: P_W] = 12'hFFF; vec[4].arr[16*P_W +: P_W] = 12'h001;
    vec[4].arr[23*P_W +: P_W] = 12'hFFF;
    vec[4].pat[0 +: P_W] = 12'hFFF; vec[4].pat[P_W +: P_W] = 12'h001; vec[4].en = 4'b0011;
    vec[4].hits[0] = 1; vec[4].hits[7] = 1; vec[4].hits[8] = 1;
    vec[4].hits[16] = 1; vec[4].hits[23] = 1; vec[4].rand_rdy = 1;
`ifdef PAT_MASK_EN
    vec[5].arr[5*P_W +: P_W] = 12'hAB7; vec[5].arr[6*P_W +: P_W] = 12'hAC7;
    vec[5].pat[0 +: P_W] = 12'hAB0; vec[5].mask[0 +: P_W] = 12'hFF0;
    vec[5].en = 4'b0001; vec[5].hits[5] = 1;
`endif

    rst = 1'b0; start = 1'b0; out_ready = 1'b0; arr = '0; pat = '0; pat_en = '0;
`ifdef PAT_MASK_EN
    pat_mask = '0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_vld", out_valid, 0); chk("rst_idx", out_idx, 0);
    chk("rst_done", done, 0); chk("rst_cnt", match_cnt, 0);
    rst = 1'b1;

    for (int k = 0; k < NV; k++) run_vec(vec[k]);

    // reset during EMIT aborts the scan without a done pulse
    begin
      int w;
      @(negedge clk);
      arr = vec[2].arr; pat = vec[2].pat; pat_en = vec[2].en; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (!out_valid && w < 20) begin @(negedge clk); w++; end
      chk("rst_wait_vld", out_valid, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arst_busy", busy, 0); chk("arst_vld", out_valid, 0); chk("arst_idx", out_idx, 0);
      chk("arst_done", done, 0); chk("arst_cnt", match_cnt, 0);
      repeat (2) begin @(negedge clk); chk("arst_no_done", done, 0); end
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_done", done, 0);
    end
    run_vec(vec[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
